// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its result stage: default widths, control
// encodings and the buffered result entry layout.
package alu_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_RD_W  = 5;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluOr  = 3'b010,
    AluAnd = 3'b011,
    AluXor = 3'b100,
    AluShl = 3'b101,
    AluShr = 3'b110
  } alu_ctrl_e;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] result;
    logic                 zero;
    logic                 sign;
    logic [DEF_RD_W-1:0]  rd;
    logic                 wr_en;
    logic                 flag_we;
  } res_entry_t;

endpackage

// File: rtl/alu_result_stage_if.sv
// Bundle of the result stage's ALU-side, writeback-side, flag and forwarding signals.
interface alu_result_stage_if #(
  parameter int unsigned WIDTH = alu_pkg::DEF_WIDTH,
  parameter int unsigned RD_W  = alu_pkg::DEF_RD_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_zero;
  logic             in_sign;
  logic [RD_W-1:0]  in_rd;
  logic             in_wr_en;
  logic             in_flag_we;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [RD_W-1:0]  out_rd;
  logic             out_wr_en;
  logic             flag_z;
  logic             flag_s;
  logic             fwd_valid;
  logic [RD_W-1:0]  fwd_rd;
  logic [WIDTH-1:0] fwd_data;
  logic [1:0]       count;

  modport slave (
    input  in_valid, in_result, in_zero, in_sign, in_rd, in_wr_en, in_flag_we, flush,
    input  out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wr_en,
    output flag_z, flag_s, fwd_valid, fwd_rd, fwd_data, count
  );

  modport master (
    output in_valid, in_result, in_zero, in_sign, in_rd, in_wr_en, in_flag_we, flush,
    output out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wr_en,
    input  flag_z, flag_s, fwd_valid, fwd_rd, fwd_data, count
  );
endinterface

// File: rtl/alu_result_stage_fifo2_entries.sv
// Two-entry in-order buffer: entry registers, 1-bit head pointer and occupancy count.
module fifo2_entries
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  res_entry_t i_entry,
  output res_entry_t o_head,
  output res_entry_t o_tail,
  output logic [1:0] o_count
);

  res_entry_t r_entry [2];
  logic       r_head;
  logic [1:0] r_count;

  logic w_wr_idx;
  logic w_tail_idx;

  // Slot after the last occupied one; equals the head slot when empty.
  assign w_wr_idx   = r_head ^ r_count[0];
  assign w_tail_idx = r_head ^ r_count[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry[0] <= '0;
      r_entry[1] <= '0;
      r_head     <= 1'b0;
      r_count    <= 2'd0;
    end else if (i_flush) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_entry[w_wr_idx] <= i_entry;
      if (i_pop)  r_head <= ~r_head;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_entry[r_head];
  assign o_tail  = r_entry[w_tail_idx];
  assign o_count = r_count;

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: buffers ALU results, commits Z/S flags on pop and
// exports the youngest register-writing entry as a forwarding source.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::DEF_WIDTH,
  parameter int unsigned RD_W  = alu_pkg::DEF_RD_W
) (
  input logic               clk,
  input logic               rst,
  alu_result_stage_if.slave bus
);

  res_entry_t       w_entry;
  res_entry_t       w_head;
  res_entry_t       w_tail;
  logic [1:0]       w_count;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic             r_flag_z;
  logic             r_flag_s;
  logic [WIDTH-1:0] w_fwd_data;
  logic [RD_W-1:0]  w_fwd_rd;
  logic             w_fwd_valid;

  assign w_in_ready  = (w_count < 2'd2);
  assign w_out_valid = (w_count != 2'd0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  always_comb begin
    w_entry         = '0;
    w_entry.result  = bus.in_result;
    w_entry.zero    = bus.in_zero;
    w_entry.sign    = bus.in_sign;
    w_entry.rd      = bus.in_rd;
    // Register 0 is hardwired, so its writes are dropped at capture.
    w_entry.wr_en   = bus.in_wr_en && (bus.in_rd != '0);
    w_entry.flag_we = bus.in_flag_we;
  end

  fifo2_entries u_entries (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.flush),
    .i_entry (w_entry),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_count (w_count)
  );

  // A pop in a flush cycle is already architecturally complete, so it still commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flag_z <= 1'b0;
      r_flag_s <= 1'b0;
    end else if (w_pop && w_head.flag_we) begin
      r_flag_z <= w_head.zero;
      r_flag_s <= w_head.sign;
    end
  end

  always_comb begin
    w_fwd_valid = 1'b0;
    w_fwd_rd    = '0;
    w_fwd_data  = '0;
    if (w_count != 2'd0 && w_tail.wr_en) begin
      w_fwd_valid = 1'b1;
      w_fwd_rd    = w_tail.rd;
      w_fwd_data  = w_tail.result;
    end else if (w_count == 2'd2 && w_head.wr_en) begin
      w_fwd_valid = 1'b1;
      w_fwd_rd    = w_head.rd;
      w_fwd_data  = w_head.result;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_result = w_out_valid ? w_head.result : '0;
  assign bus.out_rd     = w_out_valid ? w_head.rd : '0;
  assign bus.out_wr_en  = w_out_valid && w_head.wr_en;
  assign bus.flag_z     = r_flag_z;
  assign bus.flag_s     = r_flag_s;
  assign bus.fwd_valid  = w_fwd_valid;
  assign bus.fwd_rd     = w_fwd_rd;
  assign bus.fwd_data   = w_fwd_data;
  assign bus.count      = w_count;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a queue scoreboard and flag model.
module tb_alu_result_stage;

  typedef struct {
    logic [31:0] result;
    logic        z;
    logic        s;
    logic [4:0]  rd;
    logic        wr;
    logic        fwe;
  } sb_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  sb_t  q[$];
  logic m_z;
  logic m_s;

  alu_result_stage_if #(.WIDTH(32), .RD_W(5)) bus_if ();

  alu_result_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic        fv;
    logic [4:0]  frd;
    logic [31:0] fd;
    fv = 1'b0; frd = '0; fd = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].wr) begin
        fv = 1'b1; frd = q[i].rd; fd = q[i].result;
        break;
      end
    end
    check({tag, ".count"}, 64'(bus_if.count), 64'(q.size()));
    check({tag, ".in_ready"}, 64'(bus_if.in_ready), 64'(q.size() < 2));
    check({tag, ".out_valid"}, 64'(bus_if.out_valid), 64'(q.size() != 0));
    check({tag, ".out_result"}, 64'(bus_if.out_result), 64'(q.size() != 0 ? q[0].result : 32'h0));
    check({tag, ".out_rd"}, 64'(bus_if.out_rd), 64'(q.size() != 0 ? q[0].rd : 5'h0));
    check({tag, ".out_wr_en"}, 64'(bus_if.out_wr_en), 64'(q.size() != 0 ? q[0].wr : 1'b0));
    check({tag, ".flag_z"}, 64'(bus_if.flag_z), 64'(m_z));
    check({tag, ".flag_s"}, 64'(bus_if.flag_s), 64'(m_s));
    check({tag, ".fwd_valid"}, 64'(bus_if.fwd_valid), 64'(fv));
    check({tag, ".fwd_rd"}, 64'(bus_if.fwd_rd), 64'(frd));
    check({tag, ".fwd_data"}, 64'(bus_if.fwd_data), 64'(fd));
  endtask

  // One clock: drive inputs, score any pop, advance the model, then check all outputs.
  task automatic step(input string tag, input logic iv, input logic [31:0] res,
                      input logic z, input logic s, input logic [4:0] rd, input logic wr,
                      input logic fwe, input logic ordy, input logic fl, input logic rs);
    logic do_push;
    logic do_pop;
    sb_t  e;
    bus_if.in_valid   = iv;
    bus_if.in_result  = res;
    bus_if.in_zero    = z;
    bus_if.in_sign    = s;
    bus_if.in_rd      = rd;
    bus_if.in_wr_en   = wr;
    bus_if.in_flag_we = fwe;
    bus_if.out_ready  = ordy;
    bus_if.flush      = fl;
    rst               = rs;
    #1;
    do_push = iv && (q.size() < 2);
    do_pop  = ordy && (q.size() != 0);
    if (do_pop && !rs) begin
      check({tag, ".pop_result"}, 64'(bus_if.out_result), 64'(q[0].result));
      check({tag, ".pop_rd"}, 64'(bus_if.out_rd), 64'(q[0].rd));
    end
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_z = 1'b0;
      m_s = 1'b0;
    end else begin
      if (do_pop) begin
        e = q.pop_front();
        if (e.fwe) begin
          m_z = e.z;
          m_s = e.s;
        end
      end
      if (fl) begin
        q.delete();
      end else if (do_push) begin
        e.result = res; e.z = z; e.s = s; e.rd = rd;
        e.wr = wr && (rd != 5'd0); e.fwe = fwe;
        q.push_back(e);
      end
    end
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic push(input string tag, input logic [31:0] res, input logic z, input logic s,
                      input logic [4:0] rd, input logic wr, input logic fwe, input logic ordy);
    step(tag, 1'b1, res, z, s, rd, wr, fwe, ordy, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag, input logic ordy);
    step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    clk = 1'b0;
    n_tests = 0;
    n_fail = 0;
    m_z = 1'b0;
    m_s = 1'b0;

    step("reset0", 1'b1, 32'h5, 1'b1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("reset1", 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Single op, then commit its flags.
    push("single", 32'h0000_0000, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    idle("single_pop", 1'b1);

    // Backpressure: fill, third push refused, drain in order.
    push("bp_a", 32'h11, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
    push("bp_b", 32'h22, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    push("bp_c", 32'h33, 1'b1, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
    idle("bp_pop1", 1'b1);
    idle("bp_pop2", 1'b1);

    // Push and pop together at count=1.
    push("pp_a", 32'hA, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    push("pp_b", 32'hB, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
    idle("pp_pop", 1'b1);

    // rd=0 suppression and forwarding from the youngest writer.
    push("rd0", 32'h5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    push("fwd", 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    idle("fwd_pop1", 1'b1);
    push("fwd_nowr", 32'h77, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    idle("fwd_pop2", 1'b1);
    idle("fwd_pop3", 1'b1);

    // Flag gating.
    push("fg_nowe", 32'h8000_0000, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    idle("fg_pop1", 1'b1);
    push("fg_we", 32'h8000_0000, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
    idle("fg_pop2", 1'b1);

    // Flush with same-cycle push and pop: pop still commits flags.
    push("fl_a", 32'h44, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
    push("fl_b", 32'h55, 1'b0, 1'b1, 5'd11, 1'b1, 1'b1, 1'b0);
    step("flush", 1'b1, 32'h66, 1'b0, 1'b1, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    push("post_fl", 32'h99, 1'b0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation with count=2.
    push("rs_b", 32'hAA, 1'b0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
    step("rst_mid", 1'b1, 32'hBB, 1'b1, 1'b1, 5'd15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // Short random phase against the same model.
    for (int i = 0; i < 40; i++) begin
      step("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), (i % 13 == 12), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
